// File: rtl/ibex_float2int.sv
// FP32 to 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// Fixed five-state sequence: the operand is captured on start, aligned,
// rounded and saturated, and the result is presented with a one-cycle valid.
module ibex_float2int (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] input_a_i,
   input  logic        convert_en_i,
   input  logic        unsigned_i,
   input  logic [2:0]  falu_rounding_mode_i,
   output logic [31:0] output_z_o,
   output logic        convert_valid_o,
   output logic        nv_o,
   output logic        nx_o
);

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   typedef enum logic [2:0] {IDLE, ALIGN, ROUND, PACK, DONE} state_e;

   state_e state_reg, state_next;

   // Captured operand and conversion controls
   logic [31:0] a_reg;
   logic        uns_reg;
   logic [2:0]  rm_reg;

   // ALIGN results
   logic [31:0] int_reg, int_next;
   logic        guard_reg, guard_next;
   logic        sticky_reg, sticky_next;
   logic        nan_reg, nan_next;
   logic        inf_reg, inf_next;
   logic        ovf_reg, ovf_next;

   // ROUND results
   logic [32:0] mag_reg, mag_next;
   logic        inexact_reg, inexact_next;

   // PACK results
   logic [31:0] z_next;
   logic        nv_next, nx_next;

   // Per-state strobes
   logic capture_en, align_en, round_en, pack_en;

   // Operand decode
   logic              sign;
   logic [7:0]        exp_field;
   logic [22:0]       frac;
   logic [23:0]       mant;
   logic signed [9:0] exp_unb;
   logic [4:0]        lsh;
   logic [9:0]        rsh;
   logic [48:0]       shifted;
   logic              inc;

   assign sign      = a_reg[31];
   assign exp_field = a_reg[30:23];
   assign frac      = a_reg[22:0];
   assign mant      = {exp_field != 8'd0, frac};
   assign exp_unb   = (exp_field == 8'd0) ? -10'sd126 : $signed({2'b00, exp_field}) - 10'sd127;
   assign lsh       = exp_unb[4:0] - 5'd23;
   assign rsh       = 10'd23 - $unsigned(exp_unb);

   // State register; reset aborts any conversion in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic: start only sampled in IDLE, dropping enable aborts mid-flight
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (convert_en_i) state_next = ALIGN;
         ALIGN:   state_next = convert_en_i ? ROUND : IDLE;
         ROUND:   state_next = convert_en_i ? PACK  : IDLE;
         PACK:    state_next = convert_en_i ? DONE  : IDLE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output/strobe logic per state
   always_comb begin
      convert_valid_o = 1'b0;
      capture_en      = 1'b0;
      align_en        = 1'b0;
      round_en        = 1'b0;
      pack_en         = 1'b0;
      case (state_reg)
         IDLE:    capture_en      = convert_en_i;
         ALIGN:   align_en        = 1'b1;
         ROUND:   round_en        = 1'b1;
         PACK:    pack_en         = convert_en_i;
         DONE:    convert_valid_o = 1'b1;
         default: ;
      endcase
   end

   // Alignment: integer part, guard bit and sticky bit plus special classes
   always_comb begin
      int_next    = 32'd0;
      guard_next  = 1'b0;
      sticky_next = 1'b0;
      nan_next    = (exp_field == 8'hFF) && (frac != 23'd0);
      inf_next    = (exp_field == 8'hFF) && (frac == 23'd0);
      ovf_next    = 1'b0;
      shifted     = {mant, 25'd0} >> rsh[4:0];
      if (exp_field == 8'hFF) begin
         // NaN / infinity handled purely by class
      end else if (exp_unb >= 10'sd32) begin
         ovf_next = 1'b1;
      end else if (exp_unb >= 10'sd23) begin
         int_next = {8'd0, mant} << lsh;
      end else if (rsh <= 10'd25) begin
         int_next    = {8'd0, shifted[48:25]};
         guard_next  = shifted[24];
         sticky_next = |shifted[23:0];
      end else begin
         sticky_next = |mant;
      end
   end

   // Rounding increment; unknown mode encodings fall back to RNE
   always_comb begin
      inexact_next = guard_reg | sticky_reg;
      case (rm_reg)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & inexact_next;
         RM_RUP:  inc = ~sign & inexact_next;
         RM_RMM:  inc = guard_reg;
         RM_RNE:  inc = guard_reg & (sticky_reg | int_reg[0]);
         default: inc = guard_reg & (sticky_reg | int_reg[0]);
      endcase
      mag_next = {1'b0, int_reg} + {32'd0, inc};
   end

   // Saturation and sign application; NaN saturates like +inf
   always_comb begin
      z_next  = 32'd0;
      nv_next = 1'b0;
      if (!uns_reg) begin
         if (nan_reg || (!sign && (inf_reg || ovf_reg || mag_reg > 33'h0_7FFF_FFFF))) begin
            z_next  = 32'h7FFF_FFFF;
            nv_next = 1'b1;
         end else if (sign && (inf_reg || ovf_reg || mag_reg > 33'h0_8000_0000)) begin
            z_next  = 32'h8000_0000;
            nv_next = 1'b1;
         end else begin
            z_next = sign ? (~mag_reg[31:0] + 32'd1) : mag_reg[31:0];
         end
      end else begin
         if (nan_reg || (!sign && (inf_reg || ovf_reg)) || mag_reg > 33'h0_FFFF_FFFF) begin
            z_next  = 32'hFFFF_FFFF;
            nv_next = 1'b1;
         end else if (sign && (inf_reg || ovf_reg || mag_reg != 33'd0)) begin
            z_next  = 32'd0;
            nv_next = 1'b1;
         end else begin
            z_next = mag_reg[31:0];
         end
      end
      nx_next = inexact_reg & ~nv_next;
   end

   // Datapath pipeline registers, each stage loaded only in its own state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_reg       <= 32'd0;
         uns_reg     <= 1'b0;
         rm_reg      <= RM_RNE;
         int_reg     <= 32'd0;
         guard_reg   <= 1'b0;
         sticky_reg  <= 1'b0;
         nan_reg     <= 1'b0;
         inf_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
         mag_reg     <= 33'd0;
         inexact_reg <= 1'b0;
      end else begin
         if (capture_en) begin
            a_reg   <= input_a_i;
            uns_reg <= unsigned_i;
            rm_reg  <= falu_rounding_mode_i;
         end
         if (align_en) begin
            int_reg    <= int_next;
            guard_reg  <= guard_next;
            sticky_reg <= sticky_next;
            nan_reg    <= nan_next;
            inf_reg    <= inf_next;
            ovf_reg    <= ovf_next;
         end
         if (round_en) begin
            mag_reg     <= mag_next;
            inexact_reg <= inexact_next;
         end
      end
   end

   // Result and flags change only on a completed PACK->DONE step
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         output_z_o <= 32'd0;
         nv_o       <= 1'b0;
         nx_o       <= 1'b0;
      end else if (pack_en) begin
         output_z_o <= z_next;
         nv_o       <= nv_next;
         nx_o       <= nx_next;
      end
   end

endmodule

// File: tb/tb_ibex_float2int.sv
// Self-checking bench for ibex_float2int: vector table driven through a
// scoreboard, plus hand sequences for back-to-back, abort and reset.
module tb_ibex_float2int;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a;
   logic        convert_en;
   logic        is_unsigned;
   logic [2:0]  rm;
   logic [31:0] output_z;
   logic        convert_valid;
   logic        nv;
   logic        nx;

   always #5 clk = ~clk;

   ibex_float2int dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .input_a_i           (input_a),
      .convert_en_i        (convert_en),
      .unsigned_i          (is_unsigned),
      .falu_rounding_mode_i(rm),
      .output_z_o          (output_z),
      .convert_valid_o     (convert_valid),
      .nv_o                (nv),
      .nx_o                (nx)
   );

   typedef struct {
      logic [31:0] a;
      logic        uns;
      logic [2:0]  rm;
      logic [31:0] z;
      logic        nv;
      logic        nx;
   } vec_t;

   typedef struct {
      logic [31:0] z;
      logic        nv;
      logic        nx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   valid_count = 0;
   logic prev_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic void add(input logic [31:0] a, input logic uns, input logic [2:0] r,
                               input logic [31:0] z, input logic v, input logic x);
      vec_t t;
      t.a = a; t.uns = uns; t.rm = r; t.z = z; t.nv = v; t.nx = x;
      vecs.push_back(t);
   endfunction

   // Scoreboard monitor: every valid pops one expectation
   always @(negedge clk) begin
      exp_t e;
      if (convert_valid === 1'b1) begin
         valid_count++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got z=%h with no pending conversion", output_z);
         end else begin
            e = sb.pop_front();
            check("result", output_z, e.z);
            check("nv", {31'd0, nv}, {31'd0, e.nv});
            check("nx", {31'd0, nx}, {31'd0, e.nx});
         end
         if (prev_valid === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL valid_pulse: got valid high two cycles in a row expected single pulse");
         end
      end
      prev_valid <= convert_valid;
   end

   // One conversion with en held until valid, operands scrambled after start
   task automatic run_conv(input vec_t v);
      int n;
      bit seen;
      exp_t e;
      @(negedge clk);
      input_a     = v.a;
      is_unsigned = v.uns;
      rm          = v.rm;
      convert_en  = 1'b1;
      e.z = v.z; e.nv = v.nv; e.nx = v.nx;
      sb.push_back(e);
      n = 0;
      seen = 0;
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            input_a     = $urandom;
            is_unsigned = ~v.uns;
            rm          = 3'($urandom_range(0, 7));
         end
         if (convert_valid === 1'b1) seen = 1;
      end
      check("latency", n, 4);
      convert_en = 1'b0;
      @(negedge clk);
      check("valid_cycle5", {31'd0, convert_valid}, 32'd0);
   endtask

   vec_t tmp;
   int   n;
   int   vc;

   initial begin
      rst         = 1'b1;
      input_a     = 32'd0;
      convert_en  = 1'b0;
      is_unsigned = 1'b0;
      rm          = 3'd0;
      repeat (3) @(negedge clk);
      check("reset_z", output_z, 32'd0);
      check("reset_valid", {31'd0, convert_valid}, 32'd0);
      check("reset_nv", {31'd0, nv}, 32'd0);
      check("reset_nx", {31'd0, nx}, 32'd0);
      rst = 1'b0;

      //   operand        uns  rm    result         nv nx
      add(32'h40600000, 0, 3'd0, 32'h00000004, 0, 1);
      add(32'hC0200000, 0, 3'd0, 32'hFFFFFFFE, 0, 1);
      add(32'hC0200000, 0, 3'd2, 32'hFFFFFFFD, 0, 1);
      add(32'hC0200000, 0, 3'd3, 32'hFFFFFFFE, 0, 1);
      add(32'hC0200000, 0, 3'd1, 32'hFFFFFFFE, 0, 1);
      add(32'hC0200000, 0, 3'd4, 32'hFFFFFFFD, 0, 1);
      add(32'h4F000000, 0, 3'd0, 32'h7FFFFFFF, 1, 0);
      add(32'h4F000000, 1, 3'd0, 32'h80000000, 0, 0);
      add(32'hCF000000, 0, 3'd0, 32'h80000000, 0, 0);
      add(32'h4F800000, 1, 3'd0, 32'hFFFFFFFF, 1, 0);
      add(32'h7FC00000, 0, 3'd0, 32'h7FFFFFFF, 1, 0);
      add(32'hFF800000, 1, 3'd0, 32'h00000000, 1, 0);
      add(32'hBE99999A, 1, 3'd1, 32'h00000000, 0, 1);
      add(32'h80000000, 0, 3'd0, 32'h00000000, 0, 0);
      add(32'h00000001, 0, 3'd3, 32'h00000001, 0, 1);
      add(32'h00000001, 0, 3'd0, 32'h00000000, 0, 1);
      add(32'h3F800000, 1, 3'd0, 32'h00000001, 0, 0);
      add(32'hC0200000, 1, 3'd0, 32'h00000000, 1, 0);
      add(32'h40600000, 0, 3'd7, 32'h00000004, 0, 1);
      add(32'h4F800000, 0, 3'd0, 32'h7FFFFFFF, 1, 0);
      add(32'hCF000001, 0, 3'd0, 32'h80000000, 1, 0);
      add(32'h3F000000, 0, 3'd0, 32'h00000000, 0, 1);
      add(32'h3F000000, 0, 3'd4, 32'h00000001, 0, 1);
      add(32'h3FC00000, 0, 3'd0, 32'h00000002, 0, 1);
      add(32'h4F7FFFFF, 1, 3'd0, 32'hFFFFFF00, 0, 0);
      add(32'hFF800000, 0, 3'd0, 32'h80000000, 1, 0);

      foreach (vecs[i]) run_conv(vecs[i]);

      // Back-to-back: en held, second start sampled the cycle after DONE
      @(negedge clk);
      input_a = 32'h40600000; is_unsigned = 1'b0; rm = 3'd0; convert_en = 1'b1;
      sb.push_back('{z: 32'h00000004, nv: 1'b0, nx: 1'b1});
      n = 0;
      while (convert_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_latency", n, 4);
      input_a = 32'h3FC00000;
      sb.push_back('{z: 32'h00000002, nv: 1'b0, nx: 1'b1});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (convert_valid !== 1'b1 && n < 12);
      check("b2b_second_latency", n, 5);
      convert_en = 1'b0;
      @(negedge clk);

      // Abort in ROUND: no valid, previous result retained, next start fine
      tmp.a = 32'h40600000; tmp.uns = 0; tmp.rm = 3'd0; tmp.z = 32'h4; tmp.nv = 0; tmp.nx = 1;
      run_conv(tmp);
      vc = valid_count;
      @(negedge clk);
      input_a = 32'h41200000; convert_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      convert_en = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_no_valid", vc, valid_count);
      check("abort_keep_z", output_z, 32'h00000004);
      check("abort_keep_nx", {31'd0, nx}, 32'd1);
      tmp.a = 32'h41200000; tmp.uns = 0; tmp.rm = 3'd0; tmp.z = 32'hA; tmp.nv = 0; tmp.nx = 0;
      run_conv(tmp);

      // Reset while in PACK: outputs clear at once, no valid afterwards
      tmp.a = 32'h3FC00000; tmp.uns = 0; tmp.rm = 3'd0; tmp.z = 32'h2; tmp.nv = 0; tmp.nx = 1;
      run_conv(tmp);
      vc = valid_count;
      @(negedge clk);
      input_a = 32'h4F800000; convert_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_pack_z", output_z, 32'd0);
      check("rst_pack_nx", {31'd0, nx}, 32'd0);
      check("rst_pack_nv", {31'd0, nv}, 32'd0);
      check("rst_pack_valid", {31'd0, convert_valid}, 32'd0);
      convert_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_no_valid", vc, valid_count);
      tmp.a = 32'hC0200000; tmp.uns = 0; tmp.rm = 3'd2; tmp.z = 32'hFFFFFFFD; tmp.nv = 0; tmp.nx = 1;
      run_conv(tmp);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ibex_float2int.md
# ibex_float2int

Multi-cycle FP32-to-integer converter for FCVT.W.S and FCVT.WU.S, instantiated in the execution block as a peer of the float divider and int2float converter. The execution block drives the float operand and rounding mode, and selects this unit's result and valid onto the EX result path and `ex_valid_o` when the ALU operator is a float-to-int convert. It implements RISC-V F rounding, saturation and exception-flag semantics in a fixed 4-cycle pipeline-style FSM.

## Interface
- No parameters.
- `clk_i  in  1  clock`
- `rst_i  in  1  reset`; asynchronous, active-high
- `input_a_i  in  32  FP32 operand` (from the EX operand A path)
- `convert_en_i  in  1  start/hold request`; level, held by the controller while the instruction occupies EX
- `unsigned_i  in  1  selects the conversion`; 1 = FCVT.WU.S, 0 = FCVT.W.S
- `falu_rounding_mode_i  in  3  ibex_pkg::rounding_mode_e`; encodings 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; any other value is treated as RNE
- `output_z_o  out  32  integer result`, registered
- `convert_valid_o  out  1  result valid`; one-cycle pulse
- `nv_o  out  1  invalid flag`; qualified by `convert_valid_o`
- `nx_o  out  1  inexact flag`; qualified by `convert_valid_o`

## Operation
- **States:** IDLE, ALIGN, ROUND, PACK, DONE.
- **IDLE → ALIGN:** when `convert_en_i`=1. On that edge, capture `input_a_i`, `unsigned_i` and the rounding mode.
- **Forward progress:** ALIGN → ROUND → PACK → DONE, then DONE → IDLE unconditionally.
- **Abort:** `convert_en_i`=0 in ALIGN, ROUND or PACK returns the FSM to IDLE. No valid is produced, and `output_z_o` and the flags keep their previous values.
- **Start sampling:** `convert_en_i` is sampled for a start only in IDLE. The value it has in DONE is ignored.
- **Decode:** s = sign, e = exponent field, f = fraction.
  - Normal: m = {1,f}, E = e−127.
  - e=0: m = {0,f}, E = −126.
- **ALIGN:**
  - E ≥ 32: set the overflow flag.
  - 23 ≤ E ≤ 31: int = m<<(E−23), with guard and sticky both 0.
  - E < 23, with shift sh = 23−E:
    - sh ≤ 25: int = m>>sh, guard = m[sh−1], sticky = OR of m[sh−2:0].
    - sh > 25: int = 0, guard = 0, sticky = (m≠0).
  - Register a 32-bit int, guard, sticky and the special class (NaN, ±inf, overflow).
- **ROUND:** inexact = guard|sticky. The increment inc is:
  - RNE: guard & (sticky | int[0])
  - RTZ: 0
  - RDN: s & inexact
  - RUP: ~s & inexact
  - RMM: guard
  - Result: mag = int + inc, 33 bits wide.
- **PACK, signed:**
  - NaN or +inf, or (s=0 and mag > 2^31−1): result 0x7FFFFFFF, nv=1.
  - −inf or (s=1 and mag > 2^31): result 0x80000000, nv=1.
  - Otherwise: result = s ? −mag : mag.
- **PACK, unsigned:**
  - NaN, +inf, or mag > 2^32−1: result 0xFFFFFFFF, nv=1.
  - −inf, or (s=1 and mag ≠ 0): result 0, nv=1.
  - Otherwise: result = mag.
- **Flags:**
  - nx = inexact & ~nv.
  - −0.0 and negatives that round to 0 give result 0 with nv=0.
- **DONE:** `convert_valid_o`=1. `output_z_o`, `nv_o` and `nx_o` are updated on the PACK→DONE edge and held until the next PACK→DONE edge.

## Timing
- **Reset:** `rst_i`=1 asynchronously forces the state to IDLE and `output_z_o`=0, `convert_valid_o`=0, `nv_o`=0, `nx_o`=0. This includes reset mid-conversion. No valid is produced after reset is released unless a new start occurs.
- **Latency:** start in cycle 0 (IDLE with en=1); `convert_valid_o` is high in cycle 4 only. The FSM is back in IDLE in cycle 5.
- **Back-to-back:** with en held high, the next start is sampled in cycle 5, so throughput is one conversion per 5 cycles.
- **Valid pulse:** `convert_valid_o` is never high for two consecutive cycles.
- **Operand stability:** the operand and mode are sampled only at start. Changes to them during ALIGN–DONE have no effect.

## Test plan
- **Basic latency:** 0x40600000 (3.5), signed, RNE, en held high → cycle 4 valid, result 0x00000004, nx=1, nv=0. Valid is low in cycles 1–3 and in cycle 5.
- **Rounding modes on 0xC0200000 (−2.5), signed:** RNE → 0xFFFFFFFE; RDN → 0xFFFFFFFD; RUP → 0xFFFFFFFE; RTZ → 0xFFFFFFFE; RMM → 0xFFFFFFFD. nx=1 in every case.
- **Range boundaries:**
  - 0x4F000000 (2^31) signed → 0x7FFFFFFF, nv=1.
  - 0x4F000000 unsigned → 0x80000000, no flags.
  - 0xCF000000 (−2^31) signed → 0x80000000, no flags.
  - 0x4F800000 (2^32) unsigned → 0xFFFFFFFF, nv=1.
- **Specials:**
  - 0x7FC00000 (NaN) signed → 0x7FFFFFFF, nv=1.
  - 0xFF800000 (−inf) unsigned → 0, nv=1.
  - 0xBE99999A (−0.3) unsigned RTZ → 0, nx=1, nv=0.
  - 0x80000000 (−0.0) → 0, no flags.
- **Denormal:** 0x00000001 with RUP → 1, nx=1. The same input with RNE → 0, nx=1.
- **Abort and reset:**
  - en dropped in ROUND → no valid pulse; previous output_z_o is retained; the next start completes normally.
  - rst_i pulsed in PACK → all outputs read 0 immediately; no valid pulse follows.
